// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage: micro-op layout, ALU/FU codes,
// RV32 opcode and funct7 values, and the funct3 -> ALUOp helper.
package decode_pkg;

  localparam int XLEN_W   = 32;
  localparam int PC_WIDTH = 9;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_LUI   = 4'b1000;
  localparam logic [3:0] ALU_AUIPC = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLTU  = 4'b1011;

  localparam logic [1:0] FU_ALU    = 2'b00;
  localparam logic [1:0] FU_BRANCH = 2'b01;
  localparam logic [1:0] FU_LSU    = 2'b10;
  localparam logic [1:0] FU_MULDIV = 2'b11;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic ALUsrc;
    logic Branch;
    logic Memread;
    logic Memwrite;
    logic Regwrite;
  } ctrl_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN_W-1:0]   imm;
    logic [3:0]          ALUOp;
    logic [1:0]          FUtype;
    ctrl_t               flags;
    logic                illegal;
  } uop_t;

  // alt selects the funct7=0100000 variant (SUB for 000, SRA for 101)
  function automatic logic [3:0] alu_op_for(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Combinational RV32I(+M) decoder: raw instruction and PC in, one micro-op out.
// Illegal encodings still produce a micro-op, but with all side-effect flags and rd cleared.
module rv32_decode_comb
  import decode_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [XLEN_W-1:0]   instruction,
  input  logic [PC_WIDTH-1:0] pc,
  output uop_t                uop
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic [4:0]        w_rd;
  logic [XLEN_W-1:0] w_immI;
  logic [XLEN_W-1:0] w_immS;
  logic [XLEN_W-1:0] w_immB;
  logic [XLEN_W-1:0] w_immU;
  logic [XLEN_W-1:0] w_immJ;
  logic [XLEN_W-1:0] w_shamt;
  logic              w_bad;

  assign w_opcode = instruction[6:0];
  assign w_rd     = instruction[11:7];
  assign w_funct3 = instruction[14:12];
  assign w_rs1    = instruction[19:15];
  assign w_rs2    = instruction[24:20];
  assign w_funct7 = instruction[31:25];

  assign w_immI  = {{20{instruction[31]}}, instruction[31:20]};
  assign w_immS  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign w_immB  = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
  assign w_immU  = {instruction[31:12], 12'b0};
  assign w_immJ  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
  assign w_shamt = {27'b0, instruction[24:20]};

  always_comb begin
    uop    = '0;
    uop.pc = pc;
    w_bad  = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC: begin
        uop.rd             = w_rd;
        uop.imm            = w_immU;
        uop.ALUOp          = (w_opcode == OP_LUI) ? ALU_LUI : ALU_AUIPC;
        uop.flags.ALUsrc   = 1'b1;
        uop.flags.Regwrite = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        uop.rd             = w_rd;
        uop.ALUOp          = ALU_ADD;
        uop.FUtype         = FU_BRANCH;
        uop.flags.ALUsrc   = 1'b1;
        uop.flags.Branch   = 1'b1;
        uop.flags.Regwrite = 1'b1;
        if (w_opcode == OP_JAL) begin
          uop.imm = w_immJ;
        end else begin
          uop.rs1 = w_rs1;
          uop.imm = w_immI;
          w_bad   = (w_funct3 != 3'b000);
        end
      end
      OP_BRANCH: begin
        uop.rs1          = w_rs1;
        uop.rs2          = w_rs2;
        uop.imm          = w_immB;
        uop.ALUOp        = {1'b0, w_funct3};
        uop.FUtype       = FU_BRANCH;
        uop.flags.Branch = 1'b1;
        w_bad            = (w_funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        uop.rs1            = w_rs1;
        uop.rd             = w_rd;
        uop.imm            = w_immI;
        uop.ALUOp          = {1'b0, w_funct3};
        uop.FUtype         = FU_LSU;
        uop.flags.ALUsrc   = 1'b1;
        uop.flags.Memread  = 1'b1;
        uop.flags.Regwrite = 1'b1;
        w_bad              = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        uop.rs1            = w_rs1;
        uop.rs2            = w_rs2;
        uop.imm            = w_immS;
        uop.ALUOp          = {1'b0, w_funct3};
        uop.FUtype         = FU_LSU;
        uop.flags.ALUsrc   = 1'b1;
        uop.flags.Memwrite = 1'b1;
        w_bad              = (w_funct3 > 3'b010);
      end
      OP_IMM: begin
        uop.rs1            = w_rs1;
        uop.rd             = w_rd;
        uop.imm            = w_immI;
        uop.ALUOp          = alu_op_for(w_funct3, 1'b0);
        uop.flags.ALUsrc   = 1'b1;
        uop.flags.Regwrite = 1'b1;
        // shift-immediates reuse the upper bits as funct7, so the immediate is just shamt
        if (w_funct3 == 3'b001) begin
          uop.imm = w_shamt;
          w_bad   = (w_funct7 != F7_BASE);
        end else if (w_funct3 == 3'b101) begin
          uop.imm   = w_shamt;
          uop.ALUOp = alu_op_for(w_funct3, w_funct7 == F7_ALT);
          w_bad     = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
        end
      end
      OP_REG: begin
        uop.rs1            = w_rs1;
        uop.rs2            = w_rs2;
        uop.rd             = w_rd;
        uop.flags.Regwrite = 1'b1;
        if (EN_M && (w_funct7 == F7_MULDIV)) begin
          uop.FUtype = FU_MULDIV;
          uop.ALUOp  = {1'b0, w_funct3};
        end else if (w_funct7 == F7_BASE) begin
          uop.ALUOp = alu_op_for(w_funct3, 1'b0);
        end else if ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
          uop.ALUOp = alu_op_for(w_funct3, 1'b1);
        end else begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase

    if (w_bad) begin
      uop.illegal        = 1'b1;
      uop.rd             = 5'd0;
      uop.flags.Regwrite = 1'b0;
      uop.flags.Memread  = 1'b0;
      uop.flags.Memwrite = 1'b0;
      uop.flags.Branch   = 1'b0;
    end
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes the fetch instruction and buffers micro-ops in a DEPTH-entry
// FIFO with valid/ready on both sides and a flush that empties the queue.
module decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 9,
  parameter int DEPTH = 4,
  parameter bit EN_M  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [XLEN-1:0] instruction,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [PC_W-1:0] o_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] immediate,
  output logic [3:0]      ALUOp,
  output logic [1:0]      FUtype,
  output logic            ALUsrc,
  output logic            Branch,
  output logic            Memread,
  output logic            Memwrite,
  output logic            Regwrite,
  output logic            illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  uop_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  uop_t             w_decoded;
  uop_t             w_head;
  logic             w_push;
  logic             w_pop;

  rv32_decode_comb #(.EN_M(EN_M)) u_decode (
    .instruction (instruction),
    .pc          (i_pc),
    .uop         (w_decoded)
  );

  // Ready comes only from the registered count, so a full queue refuses a push
  // even when the head is popped in the same cycle.
  assign o_ready = (r_count != FULL_COUNT);
  assign o_valid = (r_count != '0);
  assign w_push  = i_valid && o_ready && !flush;
  assign w_pop   = o_valid && i_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset; the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= w_decoded;
  end

  assign w_head    = o_valid ? r_mem[r_rdPtr] : '0;
  assign o_pc      = w_head.pc;
  assign rs1       = w_head.rs1;
  assign rs2       = w_head.rs2;
  assign rd        = w_head.rd;
  assign immediate = w_head.imm;
  assign ALUOp     = w_head.ALUOp;
  assign FUtype    = w_head.FUtype;
  assign ALUsrc    = w_head.flags.ALUsrc;
  assign Branch    = w_head.flags.Branch;
  assign Memread   = w_head.flags.Memread;
  assign Memwrite  = w_head.flags.Memwrite;
  assign Regwrite  = w_head.flags.Regwrite;
  assign illegal   = w_head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode fields, FIFO ordering/backpressure, flush and reset.
// A second instance with EN_M=0 shares the same stimulus for the M-extension check.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        reset, flush, i_valid, i_ready;
  logic [31:0] instruction;
  logic [8:0]  i_pc;

  logic        o_ready, o_valid, ALUsrc, Branch, Memread, Memwrite, Regwrite, illegal;
  logic [8:0]  o_pc;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] immediate;
  logic [3:0]  ALUOp;
  logic [1:0]  FUtype;

  logic        nmReady, nmValid, nmALUsrc, nmBranch, nmMemread, nmMemwrite, nmRegwrite, nmIllegal;
  logic [8:0]  nmPc;
  logic [4:0]  nmRs1, nmRs2, nmRd;
  logic [31:0] nmImm;
  logic [3:0]  nmALUOp;
  logic [1:0]  nmFUtype;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_queue #(.XLEN(32), .PC_W(9), .DEPTH(4), .EN_M(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .instruction(instruction), .i_pc(i_pc),
    .i_valid(i_valid), .o_ready(o_ready), .i_ready(i_ready), .o_valid(o_valid), .o_pc(o_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate), .ALUOp(ALUOp), .FUtype(FUtype),
    .ALUsrc(ALUsrc), .Branch(Branch), .Memread(Memread), .Memwrite(Memwrite),
    .Regwrite(Regwrite), .illegal(illegal)
  );

  decode_queue #(.XLEN(32), .PC_W(9), .DEPTH(4), .EN_M(1'b0)) dutNoM (
    .clk(clk), .reset(reset), .flush(flush), .instruction(instruction), .i_pc(i_pc),
    .i_valid(i_valid), .o_ready(nmReady), .i_ready(i_ready), .o_valid(nmValid), .o_pc(nmPc),
    .rs1(nmRs1), .rs2(nmRs2), .rd(nmRd), .immediate(nmImm), .ALUOp(nmALUOp), .FUtype(nmFUtype),
    .ALUsrc(nmALUsrc), .Branch(nmBranch), .Memread(nmMemread), .Memwrite(nmMemwrite),
    .Regwrite(nmRegwrite), .illegal(nmIllegal)
  );

  function automatic logic [31:0] addi(input int k);
    return {12'(k), 5'd0, 3'b000, 5'(k), 7'b0010011};
  endfunction

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; instruction = '0; i_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_o_valid got=%0b exp=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_o_ready got=%0b exp=1", o_ready); end
    checks++; if ({rd, rs1, rs2, immediate, ALUOp, illegal, Regwrite} !== '0) begin failures++; $display("[TB] FAIL reset_outputs got rd=%0d imm=%0h aluop=%0h", rd, immediate, ALUOp); end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    instruction = 32'h00500093; i_pc = 9'h004; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1) begin failures++; $display("[TB] FAIL addi_valid got=%0b exp=1", o_valid); end
    checks++; if (rd !== 5'd1) begin failures++; $display("[TB] FAIL addi_rd got=%0d exp=1", rd); end
    checks++; if (rs1 !== 5'd0) begin failures++; $display("[TB] FAIL addi_rs1 got=%0d exp=0", rs1); end
    checks++; if (immediate !== 32'd5) begin failures++; $display("[TB] FAIL addi_imm got=%0h exp=5", immediate); end
    checks++; if (ALUOp !== 4'b0000) begin failures++; $display("[TB] FAIL addi_aluop got=%0b exp=0000", ALUOp); end
    checks++; if ({ALUsrc, Regwrite, illegal} !== 3'b110) begin failures++; $display("[TB] FAIL addi_flags got=%0b exp=110", {ALUsrc, Regwrite, illegal}); end
    checks++; if (o_pc !== 9'h004) begin failures++; $display("[TB] FAIL addi_pc got=%0h exp=4", o_pc); end
    @(posedge clk); #1;
    checks++; if ({o_valid, immediate, rd} !== '0) begin failures++; $display("[TB] FAIL addi_drain got valid=%0b imm=%0h exp 0", o_valid, immediate); end
  endtask

  task automatic test_sub_srai();
    instruction = 32'h402081B3; i_pc = 9'h008; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ALUOp, rs1, rs2, rd} !== {4'b0001, 5'd1, 5'd2, 5'd3}) begin failures++; $display("[TB] FAIL sub_fields got aluop=%0b rs1=%0d rs2=%0d rd=%0d exp 0001/1/2/3", ALUOp, rs1, rs2, rd); end
    checks++; if ({ALUsrc, Regwrite} !== 2'b01) begin failures++; $display("[TB] FAIL sub_flags got=%0b exp=01", {ALUsrc, Regwrite}); end
    instruction = 32'h40335293; i_pc = 9'h00C;
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++; if ({ALUOp, immediate} !== {4'b1010, 32'd3}) begin failures++; $display("[TB] FAIL srai_fields got aluop=%0b imm=%0h exp 1010/3", ALUOp, immediate); end
    checks++; if ({ALUsrc, rs1, rd, o_pc} !== {1'b1, 5'd6, 5'd5, 9'h00C}) begin failures++; $display("[TB] FAIL srai_regs got src=%0b rs1=%0d rd=%0d pc=%0h", ALUsrc, rs1, rd, o_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_muldiv();
    instruction = 32'h023100B3; i_pc = 9'h010; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({FUtype, ALUOp, Regwrite, illegal, rd} !== {2'b11, 4'b0000, 1'b1, 1'b0, 5'd1}) begin failures++; $display("[TB] FAIL mul_enm got fu=%0b aluop=%0b rw=%0b ill=%0b rd=%0d", FUtype, ALUOp, Regwrite, illegal, rd); end
    checks++; if ({nmIllegal, nmRegwrite, nmRd} !== {1'b1, 1'b0, 5'd0}) begin failures++; $display("[TB] FAIL mul_nom got ill=%0b rw=%0b rd=%0d exp 1/0/0", nmIllegal, nmRegwrite, nmRd); end
    instruction = 32'hFFFFFFFF; i_pc = 9'h014;
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++; if ({o_valid, illegal, Regwrite, Memwrite, rd} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0}) begin failures++; $display("[TB] FAIL ones_illegal got valid=%0b ill=%0b rw=%0b rd=%0d", o_valid, illegal, Regwrite, rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_decode_table();
    logic [31:0] instrs  [12] = '{32'h00812203, 32'hFE50AE23, 32'hFFF13093, 32'h00002063,
                                  32'h40209093, 32'hFE208CE3, 32'h010000EF, 32'h12345137,
                                  32'h4020D1B3, 32'h4020C1B3, 32'h00813203, 32'h000090E7};
    logic [31:0] expImm  [12] = '{32'd8, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'd0, 32'd2, 32'hFFFFFFF8,
                                  32'd16, 32'h12345000, 32'd0, 32'd0, 32'd8, 32'd0};
    logic [3:0]  expOp   [12] = '{4'b0010, 4'b0010, 4'b1011, 4'b0010, 4'b0010, 4'b0000,
                                  4'b0000, 4'b1000, 4'b1010, 4'b0000, 4'b0011, 4'b0000};
    logic [1:0]  expFu   [12] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01,
                                  2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    // {ALUsrc, Branch, Memread, Memwrite, Regwrite}
    logic [4:0]  expFlg  [12] = '{5'b10101, 5'b10010, 5'b10001, 5'b00000, 5'b10000, 5'b01000,
                                  5'b11001, 5'b10001, 5'b00001, 5'b00000, 5'b10000, 5'b10000};
    logic        expIll  [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0]  expRd   [12] = '{5'd4, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0};
    i_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      instruction = instrs[t]; i_pc = 9'(t); i_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({o_valid, immediate, ALUOp, FUtype, ALUsrc, Branch, Memread, Memwrite, Regwrite, illegal, rd} !==
          {1'b1, expImm[t], expOp[t], expFu[t], expFlg[t], expIll[t], expRd[t]}) begin
        failures++;
        $display("[TB] FAIL table_%0d got imm=%0h op=%0b fu=%0b flags=%0b ill=%0b rd=%0d exp imm=%0h op=%0b fu=%0b flags=%0b ill=%0b rd=%0d",
                 t, immediate, ALUOp, FUtype, {ALUsrc, Branch, Memread, Memwrite, Regwrite}, illegal, rd,
                 expImm[t], expOp[t], expFu[t], expFlg[t], expIll[t], expRd[t]);
      end
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    i_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      instruction = addi(k); i_pc = 9'(k); i_valid = 1'b1;
      checks++; if (o_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_before_%0d got=%0b exp=1", k, o_ready); end
      @(posedge clk); #1;
    end
    checks++; if ({o_ready, o_valid, rd} !== {1'b0, 1'b1, 5'd1}) begin failures++; $display("[TB] FAIL full_state got ready=%0b valid=%0b rd=%0d exp 0/1/1", o_ready, o_valid, rd); end
    instruction = addi(5); i_pc = 9'd5;
    @(posedge clk); #1;
    checks++; if ({o_ready, rd, immediate} !== {1'b0, 5'd1, 32'd1}) begin failures++; $display("[TB] FAIL full_hold got ready=%0b rd=%0d imm=%0h exp 0/1/1", o_ready, rd, immediate); end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0; i_valid = 1'b0;
    checks++; if ({o_ready, rd} !== {1'b1, 5'd2}) begin failures++; $display("[TB] FAIL full_pop_refuse got ready=%0b rd=%0d exp 1/2", o_ready, rd); end
    i_ready = 1'b1;
    for (int k = 3; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++; if ({o_valid, rd} !== {1'b1, 5'(k)}) begin failures++; $display("[TB] FAIL full_order_%0d got valid=%0b rd=%0d exp 1/%0d", k, o_valid, rd, k); end
    end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_fifth_dropped got valid=%0b rd=%0d exp valid 0", o_valid, rd); end
    i_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      instruction = addi(k); i_pc = 9'(k * 4); i_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if ({o_valid, o_ready, rd, o_pc} !== {1'b1, 1'b1, 5'(k), 9'(k * 4)}) begin failures++; $display("[TB] FAIL b2b_%0d got valid=%0b ready=%0b rd=%0d pc=%0h", k, o_valid, o_ready, rd, o_pc); end
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain got valid=%0b exp 0", o_valid); end
    i_ready = 1'b0;
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      instruction = addi(k); i_pc = 9'(k); i_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if ({o_valid, rd} !== {1'b1, 5'd1}) begin failures++; $display("[TB] FAIL flush_pre got valid=%0b rd=%0d exp 1/1", o_valid, rd); end
    flush = 1'b1; instruction = addi(6); i_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if ({o_valid, o_ready, rd, immediate, ALUsrc, Regwrite} !== {1'b0, 1'b1, 5'd0, 32'd0, 2'b00}) begin failures++; $display("[TB] FAIL flush_empty got valid=%0b ready=%0b rd=%0d imm=%0h", o_valid, o_ready, rd, immediate); end
    instruction = addi(7); i_pc = 9'd7; i_ready = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++; if ({o_valid, rd, immediate} !== {1'b1, 5'd7, 32'd7}) begin failures++; $display("[TB] FAIL flush_next_push got valid=%0b rd=%0d imm=%0h exp 1/7/7", o_valid, rd, immediate); end
    i_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_alone got valid=%0b rd=%0d exp valid 0", o_valid, rd); end
    i_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      instruction = addi(k); i_pc = 9'(k); i_valid = 1'b1;
      @(posedge clk); #1;
    end
    instruction = addi(3);
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({o_valid, o_ready, rd, immediate, Regwrite} !== {1'b0, 1'b1, 5'd0, 32'd0, 1'b0}) begin failures++; $display("[TB] FAIL async_reset got valid=%0b ready=%0b rd=%0d imm=%0h", o_valid, o_ready, rd, immediate); end
    i_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    instruction = addi(9); i_pc = 9'd9; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    checks++; if ({o_valid, rd, immediate} !== {1'b1, 5'd9, 32'd9}) begin failures++; $display("[TB] FAIL post_reset_push got valid=%0b rd=%0d imm=%0h exp 1/9/9", o_valid, rd, immediate); end
    i_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_drain got valid=%0b exp 0", o_valid); end
    i_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_sub_srai();
    test_muldiv();
    test_decode_table();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Next-generation decode stage. It decodes one RV32I(+optional M) instruction per cycle into a micro-op and buffers micro-ops in a DEPTH-entry FIFO between fetch and rename, with valid/ready handshakes on both sides. Beyond the existing combinational decode it adds SRA/SRAI/SLTU/SLTIU, optional MUL/DIV decode, illegal-instruction flagging and a pipeline flush.

Parameters:
XLEN, 32, instruction/immediate width
PC_W, 9, PC width
DEPTH, 4, FIFO entries (power of 2, >=2)
EN_M, 1, 1 = decode M extension; 0 = M opcodes flagged illegal

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  discard all buffered micro-ops and the same-cycle push
instruction  in  XLEN  raw instruction from fetch
i_pc  in  PC_W  PC of instruction
i_valid  in  1  fetch offers instruction
o_ready  out  1  queue can accept (count != DEPTH)
i_ready  in  1  rename accepts head micro-op
o_valid  out  1  head micro-op valid
o_pc  out  PC_W  head PC
rs1, rs2, rd  out  5 each  register specifiers (0 when unused)
immediate  out  XLEN  decoded immediate
ALUOp  out  4  operation code
FUtype  out  2  00 ALU, 01 branch, 10 LSU, 11 MUL/DIV
ALUsrc, Branch, Memread, Memwrite, Regwrite  out  1 each  control flags
illegal  out  1  head is an illegal instruction

Behaviour:
- Reset: count=0, pointers=0, o_valid=0, all micro-op outputs 0, o_ready=1.
- Push when i_valid && o_ready; pop when o_valid && i_ready. Decode happens before the write; the FIFO stores decoded micro-ops.
- o_ready depends only on the registered count, with no combinational path from i_ready. When full, a push is refused even if a pop occurs in the same cycle.
- Latency: an instruction pushed at edge N drives o_valid=1 with its fields during cycle N+1 (empty queue case).
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
- Empty queue: o_valid=0 and all micro-op outputs are driven 0.
- Head outputs are stable while o_valid && !i_ready.
- Flush: at the next edge count and pointers return to 0. A same-cycle push and pop are ignored. Flush dominates all other events.
- Reset asserted mid-operation clears state immediately (asynchronous).
- ALUOp encoding:
  - ALU ops: ADD 0000, SUB 0001, SLL 0010, SLT 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, LUI 1000, AUIPC 1001, SRA 1010, SLTU 1011.
  - Load, store, branch and MUL/DIV use {0,funct3}.
  - JAL and JALR use ADD.
- Immediates:
  - I, S, B, U and J formats are sign-extended or shifted as in RV32I.
  - SLLI/SRLI/SRAI immediate = zero-extended instr[24:20].
- Control flags per opcode are unchanged from the current decoder. R-type funct7=0000001 with EN_M=1 sets FUtype=11, ALUOp={0,funct3}, Regwrite=1, rs1, rs2 and rd.
- illegal=1 for any of the following:
  - unknown opcode;
  - R-type funct7 not in {0000000, 0100000, 0000001(EN_M)};
  - funct7=0100000 with funct3 not in {000, 101};
  - shift-immediate funct7 not 0000000/0100000 (0100000 only with SRAI);
  - branch funct3 010/011;
  - load funct3 011/110/111;
  - store funct3 > 010;
  - JALR funct3 != 000.
- An illegal micro-op is still enqueued, with Regwrite=Memread=Memwrite=Branch=0 and rd=0.

Decomposition:
- decode_pkg holds:
  - uop_t struct (pc, rs1, rs2, rd, imm, ALUOp, FUtype, flags, illegal);
  - ALU_* and FU_* localparams;
  - opcode constants.
- Sub-module rv32_decode_comb (combinational instruction -> uop_t, parameter EN_M).
- decode_queue holds the FIFO, handshake and flush logic.

Test Plan:
- ADDI x1,x0,5 (0x00500093), i_valid=1, i_ready=1 -> next cycle o_valid=1, rd=1, rs1=0, immediate=5, ALUOp=0000, ALUsrc=1, Regwrite=1, illegal=0.
- SUB x3,x1,x2 (0x402081B3) then SRAI x5,x6,3 (0x40335293) -> ALUOp 0001 rs1=1 rs2=2 rd=3; then ALUOp 1010, immediate=3, ALUsrc=1.
- MUL x1,x2,x3 (0x023100B3): EN_M=1 -> FUtype=11, ALUOp=0000; EN_M=0 -> illegal=1, Regwrite=0. 0xFFFFFFFF -> illegal=1.
- i_ready=0, push 4 instructions (DEPTH=4) -> o_ready=0 after 4th edge, 5th held; pulse i_ready for one cycle -> order preserved, o_ready returns 1 next cycle.
- 3 entries buffered, flush=1 with i_valid=1 -> next cycle o_valid=0, outputs 0, o_ready=1; next push appears alone.
- Assert reset asynchronously mid-burst -> o_valid drops immediately, outputs 0; after release, queue accepts normally.
